// File: rtl/dffnq_vpipe.sv
// dffnq_vpipe: WIDTH-bit, DEPTH-stage pipeline register clocked on the falling edge
// of CLKN. It has per-stage valid bits, a valid/ready handshake with backpressure,
// bubble collapsing and a registered occupancy count.
module dffnq_vpipe #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      DEPTH    = 3,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic                       CLKN,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           D,
    input  logic                       DV,
    output logic                       DR,
    output logic [WIDTH-1:0]           Q,
    output logic                       QV,
    input  logic                       QR,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] d_q [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [DEPTH-1:0] adv;
    logic             up_xfer;
    logic             dn_xfer;

    // Advance chain: a stage may load if it is empty or its successor advances.
    // The running term 'a' keeps the chain free of self-reads on adv.
    always_comb begin
        logic a;
        adv            = '0;
        a              = ~v_q[DEPTH-1] | QR;
        adv[DEPTH-1]   = a;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            a      = ~v_q[i] | a;
            adv[i] = a;
        end
    end

    assign DR      = adv[0];
    assign Q       = d_q[DEPTH-1];
    assign QV      = v_q[DEPTH-1];
    assign COUNT   = count_q;
    assign up_xfer = DV & adv[0];
    assign dn_xfer = v_q[DEPTH-1] & QR;

    // Occupancy next state: one in and one out on the same edge leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (up_xfer && !dn_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!up_xfer && dn_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    // Falling-edge state update; data only loads from a valid source so Q stays
    // quiet while QV=0.
    always_ff @(negedge CLKN) begin
        if (RST) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= RST_DATA;
            end
        end else begin
            count_q <= count_d;
            if (adv[0]) begin
                v_q[0] <= DV;
                if (DV) begin
                    d_q[0] <= D;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i]) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1]) begin
                        d_q[i] <= d_q[i-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dffnq_vpipe.sv
// Bench for dffnq_vpipe: directed stimulus with a scoreboard per instance
// (DEPTH=3/WIDTH=8 and DEPTH=1/WIDTH=1).
module tb_dffnq_vpipe;

    logic CLKN = 1'b1;
    always #5 CLKN = ~CLKN;

    logic       RST;
    logic [7:0] a_d, a_q;
    logic       a_dv, a_dr, a_qv, a_qr;
    logic [1:0] a_count;
    logic       b_d, b_q, b_dv, b_dr, b_qv, b_qr;
    logic [0:0] b_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_a[$];
    logic       exp_b[$];

    dffnq_vpipe #(.WIDTH(8), .DEPTH(3), .RST_DATA(8'h00)) dut_a (
        .CLKN(CLKN), .RST(RST), .D(a_d), .DV(a_dv), .DR(a_dr),
        .Q(a_q), .QV(a_qv), .QR(a_qr), .COUNT(a_count)
    );

    dffnq_vpipe #(.WIDTH(1), .DEPTH(1), .RST_DATA(1'b0)) dut_b (
        .CLKN(CLKN), .RST(RST), .D(b_d), .DV(b_dv), .DR(b_dr),
        .Q(b_q), .QV(b_qv), .QR(b_qr), .COUNT(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // One falling edge, then settle into the low phase.
    task automatic step();
        @(negedge CLKN);
        #2;
    endtask

    // Monitors sample mid-cycle; a pop here means a transfer on the next falling edge.
    always @(posedge CLKN) begin
        logic [7:0] e;
        if (!RST) begin
            chk("a_popcount", $countones(dut_a.v_q), {30'd0, a_count});
            if (a_qv && a_qr) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_sb_underflow: got %0h required no word", a_q);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_sb_data", {24'd0, a_q}, {24'd0, e});
                end
            end
        end
    end

    always @(posedge CLKN) begin
        logic e;
        if (!RST) begin
            chk("b_popcount", $countones(dut_b.v_q), {31'd0, b_count});
            chk("b_dr_rel", {31'd0, b_dr}, {31'd0, ~b_qv | b_qr});
            if (b_qv && b_qr) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_sb_underflow: got %0h required no word", b_q);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_sb_data", {31'd0, b_q}, {31'd0, e});
                end
            end
        end
    end

    // DEPTH=1 vectors: {D, DV, QR} and expected DR before the edge, QV/Q after it.
    logic vb_d  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic vb_dv [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic vb_qr [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic vb_dr [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic vb_qv [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic vb_q  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        RST  = 1'b1;
        a_d  = 8'hFF; a_dv = 1'b1; a_qr = 1'b0;
        b_d  = 1'b0;  b_dv = 1'b0; b_qr = 1'b0;

        // Reset with a word presented: nothing captured.
        step();
        step();
        chk("rst_qv", {31'd0, a_qv}, 0);
        chk("rst_q", {24'd0, a_q}, 32'h00);
        chk("rst_count", {30'd0, a_count}, 0);
        chk("rst_dr", {31'd0, a_dr}, 1);
        chk("rst_b_qv", {31'd0, b_qv}, 0);
        RST  = 1'b0;
        a_dv = 1'b0;

        // Streaming with QR=1: 01 appears after the third edge.
        a_qr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_d  = 8'(k + 1);
            a_dv = 1'b1;
            exp_a.push_back(8'(k + 1));
            #1;
            chk("stream_dr", {31'd0, a_dr}, 1);
            step();
            if (k == 1) chk("stream_qv_early", {31'd0, a_qv}, 0);
            if (k == 2) begin
                chk("stream_first_q", {24'd0, a_q}, 32'h01);
                chk("stream_first_qv", {31'd0, a_qv}, 1);
            end
            if (k >= 2) chk("stream_count", {30'd0, a_count}, 3);
        end
        a_dv = 1'b0;
        step(); step(); step();
        chk("drain_count", {30'd0, a_count}, 0);
        chk("drain_qv", {31'd0, a_qv}, 0);
        chk("drain_q_hold", {24'd0, a_q}, 32'h04);

        // Backpressure fill.
        a_qr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_d  = 8'hA1 + 8'(k);
            a_dv = 1'b1;
            exp_a.push_back(8'hA1 + 8'(k));
            step();
        end
        chk("bp_count", {30'd0, a_count}, 3);
        chk("bp_dr", {31'd0, a_dr}, 0);
        chk("bp_q", {24'd0, a_q}, 32'hA1);
        a_d = 8'hA4;
        step();
        chk("bp_stall_q", {24'd0, a_q}, 32'hA1);
        chk("bp_stall_qv", {31'd0, a_qv}, 1);
        chk("bp_stall_count", {30'd0, a_count}, 3);
        chk("bp_stall_dr", {31'd0, a_dr}, 0);
        a_qr = 1'b1;
        exp_a.push_back(8'hA4);
        #1;
        chk("bp_full_dr", {31'd0, a_dr}, 1);
        step();
        chk("bp_swap_count", {30'd0, a_count}, 3);
        chk("bp_swap_q", {24'd0, a_q}, 32'hA2);
        a_dv = 1'b0;
        step(); step(); step();
        chk("bp_drain_count", {30'd0, a_count}, 0);

        // Bubble collapse with QR=0.
        a_qr = 1'b0;
        a_d = 8'h10; a_dv = 1'b1; exp_a.push_back(8'h10); step();
        a_dv = 1'b0; step();
        a_d = 8'h20; a_dv = 1'b1; exp_a.push_back(8'h20); step();
        a_dv = 1'b0; step();
        chk("bub_count", {30'd0, a_count}, 2);
        chk("bub_dr", {31'd0, a_dr}, 1);
        chk("bub_q", {24'd0, a_q}, 32'h10);
        chk("bub_v", {29'd0, dut_a.v_q}, 32'b110);
        a_qr = 1'b1;
        step();
        chk("bub_nogap_qv", {31'd0, a_qv}, 1);
        chk("bub_nogap_q", {24'd0, a_q}, 32'h20);
        step();
        chk("bub_empty", {30'd0, a_count}, 0);

        // Reset mid-flight.
        a_qr = 1'b0;
        a_d = 8'hB1; a_dv = 1'b1; step();
        a_d = 8'hB2; step();
        chk("mid_count", {30'd0, a_count}, 2);
        RST = 1'b1; a_d = 8'hCC;
        exp_a.delete();
        step();
        chk("mid_rst_count", {30'd0, a_count}, 0);
        chk("mid_rst_qv", {31'd0, a_qv}, 0);
        chk("mid_rst_q", {24'd0, a_q}, 32'h00);
        RST = 1'b0;
        a_qr = 1'b1; a_d = 8'h5A; a_dv = 1'b1;
        exp_a.push_back(8'h5A);
        step();
        a_dv = 1'b0;
        step();
        chk("mid_lat_qv2", {31'd0, a_qv}, 0);
        step();
        chk("mid_lat_qv3", {31'd0, a_qv}, 1);
        chk("mid_lat_q3", {24'd0, a_q}, 32'h5A);
        step();
        chk("mid_end_count", {30'd0, a_count}, 0);

        // DEPTH=1, WIDTH=1 handshake.
        for (int k = 0; k < 8; k++) begin
            b_d  = vb_d[k];
            b_dv = vb_dv[k];
            b_qr = vb_qr[k];
            #1;
            chk("b_dr", {31'd0, b_dr}, {31'd0, vb_dr[k]});
            if (vb_dr[k] && vb_dv[k]) exp_b.push_back(vb_d[k]);
            step();
            chk("b_qv", {31'd0, b_qv}, {31'd0, vb_qv[k]});
            chk("b_q", {31'd0, b_q}, {31'd0, vb_q[k]});
        end
        b_dv = 1'b0;
        step();

        chk("a_sb_drained", exp_a.size(), 0);
        chk("b_sb_drained", exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
